// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// The CPU side is a Wishbone slave serving 128-bit lines with byte enables.
// Misses evict (if dirty) and fill whole lines over a Wishbone master to L2.
// Handshake: a CPU request is valid while cpu_cyc & cpu_stb. The CPU holds the
// request steady until cpu_ack, which is high for exactly the completing cycle.
// L2 cycles hold l2_cyc/l2_stb and all address/data stable until l2_ack.
module l1_dcache #(
  parameter int SET_BITS  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          cpu_adr,
  input  logic [127:0]         cpu_dat_m,
  input  logic [15:0]          cpu_sel,
  input  logic                 cpu_we,
  input  logic                 cpu_stb,
  input  logic                 cpu_cyc,
  output logic [127:0]         cpu_dat_s,
  output logic                 cpu_ack,
  output logic [11:0]          l2_adr,
  output logic [127:0]         l2_dat_m,
  output logic [15:0]          l2_sel,
  output logic                 l2_we,
  output logic                 l2_stb,
  output logic                 l2_cyc,
  input  logic [127:0]         l2_dat_s,
  input  logic                 l2_ack,
  output logic [CNT_WIDTH-1:0] dcache_hit_counter,
  output logic [CNT_WIDTH-1:0] dcache_miss_counter
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 12 - SET_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_t;

  state_t               state_q, state_d;
  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [SETS];
  logic [TAG_W-1:0]     tag_d [SETS];
  logic [127:0]         data_q [SETS];
  logic [127:0]         data_d [SETS];
  logic [11:0]          miss_adr_q, miss_adr_d;
  logic                 refill_q, refill_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic                 req;
  logic [SET_BITS-1:0]  idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic                 hit;
  logic [SET_BITS-1:0]  fill_idx;

  assign req      = cpu_cyc & cpu_stb;
  assign idx      = cpu_adr[SET_BITS-1:0];
  assign cpu_tag  = cpu_adr[11:SET_BITS];
  assign hit      = valid_q[idx] & (tag_q[idx] == cpu_tag);
  // The victim/fill set comes from the latched miss address so a flushed
  // request (CPU address no longer held) still completes on the right line.
  assign fill_idx = miss_adr_q[SET_BITS-1:0];

  assign dcache_hit_counter  = hit_cnt_q;
  assign dcache_miss_counter = miss_cnt_q;

  // Next-state, array updates, counters and all bus outputs.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    miss_adr_d = miss_adr_q;
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cpu_ack    = 1'b0;
    cpu_dat_s  = data_q[idx];
    l2_cyc     = 1'b0;
    l2_stb     = 1'b0;
    l2_we      = 1'b0;
    l2_sel     = 16'hFFFF;
    l2_adr     = miss_adr_q;
    l2_dat_m   = data_q[fill_idx];
    case (state_q)
      S_IDLE: begin
        refill_d = 1'b0;
        if (req) begin
          if (hit) begin
            cpu_ack = 1'b1;
            // The ACK that completes a refilled miss is not a hit.
            if (!refill_q) hit_cnt_d = hit_cnt_q + CNT_ONE;
            if (cpu_we) begin
              for (int b = 0; b < 16; b++) begin
                if (cpu_sel[b]) data_d[idx][8*b +: 8] = cpu_dat_m[8*b +: 8];
              end
              dirty_d[idx] = 1'b1;
            end
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
            miss_adr_d = cpu_adr;
            state_d    = (valid_q[idx] & dirty_q[idx]) ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        l2_cyc = 1'b1;
        l2_stb = 1'b1;
        l2_we  = 1'b1;
        l2_adr = {tag_q[fill_idx], fill_idx};
        if (l2_ack) state_d = S_FILL;
      end
      S_FILL: begin
        l2_cyc = 1'b1;
        l2_stb = 1'b1;
        if (l2_ack) begin
          data_d[fill_idx]  = l2_dat_s;
          tag_d[fill_idx]   = miss_adr_q[11:SET_BITS];
          valid_d[fill_idx] = 1'b1;
          dirty_d[fill_idx] = 1'b0;
          refill_d          = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, valid/dirty bits and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_adr_q <= '0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_adr_q <= miss_adr_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed test of l1_dcache against a line-level cache model.
module tb_l1_dcache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  cpu_adr = '0;
  logic [127:0] cpu_dat_m = '0;
  logic [15:0]  cpu_sel = '0;
  logic         cpu_we = 1'b0;
  logic         cpu_stb = 1'b0;
  logic         cpu_cyc = 1'b0;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic [11:0]  l2_adr;
  logic [127:0] l2_dat_m;
  logic [15:0]  l2_sel;
  logic         l2_we, l2_stb, l2_cyc;
  logic [127:0] l2_dat_s = '0;
  logic         l2_ack = 1'b0;
  logic [15:0]  dcache_hit_counter, dcache_miss_counter;

  l1_dcache #(.SET_BITS(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_cyc(cpu_cyc),
    .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack), .l2_adr(l2_adr),
    .l2_dat_m(l2_dat_m), .l2_sel(l2_sel), .l2_we(l2_we), .l2_stb(l2_stb),
    .l2_cyc(l2_cyc), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
    .dcache_hit_counter(dcache_hit_counter),
    .dcache_miss_counter(dcache_miss_counter)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Line-level reference model.
  logic [127:0] m_l2   [4096];
  logic [127:0] m_data [8];
  logic [8:0]   m_tag  [8];
  logic [7:0]   m_valid, m_dirty;
  int           m_hit, m_miss;

  // Expectations for the per-cycle compare process.
  logic         l2_allowed = 1'b0;
  logic         exp_wb_on  = 1'b0;
  logic [11:0]  exp_wb_adr = '0;
  logic [127:0] exp_wb_dat = '0;
  logic [11:0]  exp_fill_adr = '0;
  logic [127:0] exp_rd = '0;
  logic [127:0] rd_last = '0;

  // L2 slave state.
  logic [127:0] l2_mem [4096];
  int           l2_lat = 0;
  int           wait_cnt = 0;
  logic [11:0]  wb_adr_log = '0;
  logic [127:0] wb_dat_log = '0;

  function automatic logic [127:0] pattern(input logic [11:0] a);
    return {4'h0, a, 96'h0123456789ABCDEF01234567, 16'hAA55};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // L2 slave: acks each phase after l2_lat wait cycles, one-cycle ack pulse.
  always @(negedge clk) begin
    logic prev;
    prev   = l2_ack;
    l2_ack = 1'b0;
    if (l2_cyc && l2_stb && !rst) begin
      if (prev) wait_cnt = 0;
      if (wait_cnt >= l2_lat) begin
        if (l2_we) begin
          l2_mem[l2_adr] = l2_dat_m;
          wb_adr_log     = l2_adr;
          wb_dat_log     = l2_dat_m;
        end
        l2_dat_s = l2_mem[l2_adr];
        l2_ack   = 1'b1;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // scoreboard compare: CPU read data on ACK, L2 bus whenever a cycle is open.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ack && !cpu_we) chk("rd_data", cpu_dat_s, exp_rd);
      if (!l2_allowed) chk("l2_idle", {127'b0, l2_cyc}, 128'd0);
      if (l2_cyc) begin
        chk("l2_sel", {112'b0, l2_sel}, {112'b0, 16'hFFFF});
        chk("l2_stb", {127'b0, l2_stb}, 128'd1);
        if (l2_we) begin
          chk("wb_expected", {127'b0, exp_wb_on}, 128'd1);
          chk("wb_adr", {116'b0, l2_adr}, {116'b0, exp_wb_adr});
          chk("wb_dat", l2_dat_m, exp_wb_dat);
        end else begin
          chk("fill_adr", {116'b0, l2_adr}, {116'b0, exp_fill_adr});
        end
      end
    end
  end

  task automatic model_reset();
    m_valid = '0;
    m_dirty = '0;
    m_hit   = 0;
    m_miss  = 0;
  endtask

  // Work out what the access must do before it is driven.
  task automatic model_prepare(input logic [11:0] adr, output logic hit);
    logic [2:0] i;
    i   = adr[2:0];
    hit = m_valid[i] && (m_tag[i] == adr[11:3]);
    exp_wb_on    = !hit && m_valid[i] && m_dirty[i];
    exp_wb_adr   = {m_tag[i], i};
    exp_wb_dat   = m_data[i];
    exp_fill_adr = adr;
    exp_rd       = hit ? m_data[i] : m_l2[adr];
    l2_allowed   = !hit;
  endtask

  task automatic model_install(input logic [11:0] adr);
    logic [2:0] i;
    i = adr[2:0];
    if (m_valid[i] && m_dirty[i]) m_l2[{m_tag[i], i}] = m_data[i];
    m_data[i]  = m_l2[adr];
    m_tag[i]   = adr[11:3];
    m_valid[i] = 1'b1;
    m_dirty[i] = 1'b0;
    m_miss++;
  endtask

  task automatic check_counters(input string name);
    chk({name, "_hit_cnt"}, {112'b0, dcache_hit_counter}, 128'(m_hit));
    chk({name, "_miss_cnt"}, {112'b0, dcache_miss_counter}, 128'(m_miss));
  endtask

  // driver: one CPU access, held until ACK; checks latency and counters.
  task automatic access(input string name, input logic [11:0] adr, input logic we,
                        input logic [15:0] sel, input logic [127:0] dat,
                        input int lat, input int exp_lat);
    logic hit;
    int   n;
    logic done;
    l2_lat = lat;
    model_prepare(adr, hit);
    @(posedge clk); #1;
    cpu_adr = adr; cpu_we = we; cpu_sel = sel; cpu_dat_m = dat;
    cpu_cyc = 1'b1; cpu_stb = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n <= 40) begin
      @(negedge clk);
      if (cpu_ack) begin
        done = 1'b1;
        rd_last = cpu_dat_s;
      end else begin
        n++;
      end
    end
    chk({name, "_latency"}, 128'(n), 128'(exp_lat));
    if (!hit) model_install(adr);
    else m_hit++;
    if (we) begin
      for (int b = 0; b < 16; b++)
        if (sel[b]) m_data[adr[2:0]][8*b +: 8] = dat[8*b +: 8];
      m_dirty[adr[2:0]] = 1'b1;
    end
    @(posedge clk); #1;
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    l2_allowed = 1'b0;
    check_counters(name);
  endtask

  // driver: read miss whose request is withdrawn while the fill is open.
  task automatic flush_access(input string name, input logic [11:0] adr, input int lat);
    logic hit;
    int   n;
    l2_lat = lat;
    model_prepare(adr, hit);
    @(posedge clk); #1;
    cpu_adr = adr; cpu_we = 1'b0; cpu_sel = '0; cpu_cyc = 1'b1; cpu_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_cyc && !l2_we) && n < 40);
    chk({name, "_fill_seen"}, {127'b0, l2_cyc & ~l2_we}, 128'd1);
    cpu_cyc = 1'b0; cpu_stb = 1'b0;
    n = 0;
    while (l2_cyc && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_fill_done"}, {127'b0, l2_cyc}, 128'd0);
    for (int k = 0; k < 3; k++) begin
      chk({name, "_no_ack"}, {127'b0, cpu_ack}, 128'd0);
      @(negedge clk);
    end
    if (!hit) model_install(adr);
    l2_allowed = 1'b0;
    check_counters(name);
  endtask

  // driver: dirty miss interrupted by reset during the writeback.
  task automatic reset_in_writeback(input string name, input logic [11:0] adr, input int lat);
    logic hit;
    int   n;
    l2_lat = lat;
    model_prepare(adr, hit);
    @(posedge clk); #1;
    cpu_adr = adr; cpu_we = 1'b0; cpu_sel = '0; cpu_cyc = 1'b1; cpu_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_cyc && l2_we) && n < 40);
    chk({name, "_wb_seen"}, {127'b0, l2_cyc & l2_we}, 128'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_cyc = 1'b0; cpu_stb = 1'b0;
    l2_allowed = 1'b0;
    model_reset();
    @(negedge clk);
    chk({name, "_l2_cyc"}, {127'b0, l2_cyc}, 128'd0);
    chk({name, "_cpu_ack"}, {127'b0, cpu_ack}, 128'd0);
    check_counters(name);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      m_l2[a]   = pattern(12'(a));
      l2_mem[a] = pattern(12'(a));
    end
    for (int i = 0; i < 8; i++) begin
      m_data[i] = '0;
      m_tag[i]  = '0;
    end
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack", {127'b0, cpu_ack}, 128'd0);
    chk("rst_l2_ctl", {125'b0, l2_cyc, l2_stb, l2_we}, 128'd0);
    chk("rst_l2_sel", {112'b0, l2_sel}, {112'b0, 16'hFFFF});
    check_counters("rst");

    // Clean read miss, then read hit.
    access("rd_miss_010", 12'h010, 1'b0, 16'h0, '0, 0, 2);
    chk("rd_miss_010_lit", rd_last, 128'h0010_0123_4567_89ab_cdef_0123_4567_aa55);
    access("rd_hit_010", 12'h010, 1'b0, 16'h0, '0, 0, 0);
    chk("rd_hit_010_lit", rd_last, 128'h0010_0123_4567_89ab_cdef_0123_4567_aa55);
    chk("hit_cnt_lit1", {112'b0, dcache_hit_counter}, 128'd1);

    // Partial write hit, read back the merge.
    access("wr_hit_010", 12'h010, 1'b1, 16'h0003,
           128'h1111_2222_3333_4444_5555_6666_7777_beef, 0, 0);
    access("rd_merge_010", 12'h010, 1'b0, 16'h0, '0, 0, 0);
    chk("rd_merge_010_lit", rd_last, 128'h0010_0123_4567_89ab_cdef_0123_4567_beef);

    // Dirty conflict miss: writeback of the merged line, then fill.
    access("rd_evict_018", 12'h018, 1'b0, 16'h0, '0, 1, 5);
    chk("wb_adr_lit1", {116'b0, wb_adr_log}, {116'b0, 12'h010});
    chk("wb_dat_lit1", wb_dat_log, 128'h0010_0123_4567_89ab_cdef_0123_4567_beef);
    chk("rd_evict_018_lit", rd_last, 128'h0018_0123_4567_89ab_cdef_0123_4567_aa55);

    // Write miss to a clean set allocates then merges.
    access("wr_miss_0a3", 12'h0A3, 1'b1, 16'hF000,
           128'hdead_c0de_0000_0000_0000_0000_0000_0000, 0, 2);
    chk("hit_cnt_lit2", {112'b0, dcache_hit_counter}, 128'd3);
    chk("miss_cnt_lit2", {112'b0, dcache_miss_counter}, 128'd3);
    access("rd_0a3", 12'h0A3, 1'b0, 16'h0, '0, 0, 0);
    chk("rd_0a3_lit", rd_last, 128'hdead_c0de_4567_89ab_cdef_0123_4567_aa55);
    access("rd_evict_0ab", 12'h0AB, 1'b0, 16'h0, '0, 0, 3);
    chk("wb_adr_lit2", {116'b0, wb_adr_log}, {116'b0, 12'h0A3});
    chk("wb_dat_lit2", wb_dat_log, 128'hdead_c0de_4567_89ab_cdef_0123_4567_aa55);

    // Request withdrawn during fill; line still installed and hits later.
    flush_access("flush_025", 12'h025, 2);
    access("rd_hit_025", 12'h025, 1'b0, 16'h0, '0, 0, 0);
    chk("rd_hit_025_lit", rd_last, 128'h0025_0123_4567_89ab_cdef_0123_4567_aa55);

    // Reset mid-writeback abandons L2 and invalidates the cache.
    access("wr_hit_025", 12'h025, 1'b1, 16'hFFFF,
           128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 0, 0);
    reset_in_writeback("rst_wb_02d", 12'h02D, 3);
    access("rd_after_rst_025", 12'h025, 1'b0, 16'h0, '0, 0, 2);
    chk("rd_after_rst_025_lit", rd_last, 128'h0025_0123_4567_89ab_cdef_0123_4567_aa55);
    chk("miss_cnt_lit3", {112'b0, dcache_miss_counter}, 128'd1);

    // final report
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
